// File: rtl/bbc_mem_pkg.sv
// Shared types and widths for the video/CPU RAM slot arbiter.
// Both the slot timer and the arbiter FSM import this package.
package bbc_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic {
        VIDEO = 1'b0,
        CPU   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic owner_e other_owner(input owner_e o);
        return (o == VIDEO) ? CPU : VIDEO;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Slot counter and owner toggle: VIDEO and CPU alternate slots of SLOT_LEN cycles,
// starting with VIDEO after reset. cpu_phase marks the first cycle of each CPU slot.
module slot_timer
    import bbc_mem_pkg::*;
#(
    parameter int SLOT_LEN = 25
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] slot_cnt_o,
    output owner_e           owner_o,
    output logic             cpu_phase_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        owner_d = owner_q;
        if (cnt_q == LAST) begin
            cnt_d   = '0;
            owner_d = other_owner(owner_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            owner_q <= VIDEO;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    assign slot_cnt_o  = cnt_q;
    assign owner_o     = owner_q;
    assign cpu_phase_o = (cnt_q == '0) && (owner_q == CPU);

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-sliced arbiter sharing one synchronous RAM port between video fetch and CPU.
// One access per slot, decided at slot_cnt 0; ack lands exactly 3 cycles later.
module mem_slot_arbiter
    import bbc_mem_pkg::*;
#(
    parameter int SLOT_LEN = 25,
    parameter int BORROW   = 1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_ack,
    output logic              cpu_phase,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [CNT_W-1:0] slot_cnt;
    owner_e           owner;

    slot_timer #(
        .SLOT_LEN(SLOT_LEN)
    ) u_slot_timer (
        .clk_i      (CLK100MHZ),
        .rst_ni     (CPU_RESETN),
        .slot_cnt_o (slot_cnt),
        .owner_o    (owner),
        .cpu_phase_o(cpu_phase)
    );

    arb_state_e        state_q, state_d;
    owner_e            gnt_q, gnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;

    mem_req_t cpu_req_s, vid_req_s;
    logic     slot_start, own_req, oth_req;

    // Video is read-only, so its request can never carry a write.
    assign cpu_req_s  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign vid_req_s  = '{we: 1'b0, addr: vid_addr, wdata: '0};
    assign slot_start = (slot_cnt == '0);
    assign own_req    = (owner == CPU) ? cpu_req : vid_req;
    assign oth_req    = (owner == CPU) ? vid_req : cpu_req;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        req_d       = req_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_data_d  = vid_data_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        cpu_ack     = 1'b0;
        vid_ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (slot_start && (own_req || ((BORROW != 0) && oth_req))) begin
                    gnt_d   = own_req ? owner : other_owner(owner);
                    req_d   = (gnt_d == CPU) ? cpu_req_s : vid_req_s;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_en  = 1'b1;
                ram_we  = req_q.we;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // RAM data is valid this cycle; registering it makes it visible with ack.
                if (gnt_q == VIDEO) begin
                    vid_data_d = ram_rdata;
                end else if (!req_q.we) begin
                    cpu_rdata_d = ram_rdata;
                end
                state_d = ACK;
            end
            ACK: begin
                cpu_ack = (gnt_q == CPU);
                vid_ack = (gnt_q == VIDEO);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= IDLE;
            gnt_q       <= VIDEO;
            req_q       <= '0;
            cpu_rdata_q <= '0;
            vid_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            req_q       <= req_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_data_q  <= vid_data_d;
        end
    end

    assign ram_addr  = req_q.addr;
    assign ram_wdata = req_q.wdata;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_data  = vid_data_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: BORROW=1 instance (a) and BORROW=0 instance (b),
// each with a small synchronous RAM model and an expected-access scoreboard queue.
module tb_mem_slot_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        cpu_req_a, cpu_we_a, cpu_ack_a, vid_req_a, vid_ack_a, cpu_phase_a, ram_en_a, ram_we_a;
    logic [14:0] cpu_addr_a, vid_addr_a, ram_addr_a;
    logic [7:0]  cpu_wdata_a, cpu_rdata_a, vid_data_a, ram_wdata_a, ram_rdata_a;
    logic        cpu_req_b, cpu_we_b, cpu_ack_b, vid_req_b, vid_ack_b, cpu_phase_b, ram_en_b, ram_we_b;
    logic [14:0] cpu_addr_b, vid_addr_b, ram_addr_b;
    logic [7:0]  cpu_wdata_b, cpu_rdata_b, vid_data_b, ram_wdata_b, ram_rdata_b;

    mem_slot_arbiter #(.SLOT_LEN(25), .BORROW(1)) dut_a (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
        .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a),
        .vid_req(vid_req_a), .vid_addr(vid_addr_a), .vid_data(vid_data_a), .vid_ack(vid_ack_a),
        .cpu_phase(cpu_phase_a), .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
        .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    mem_slot_arbiter #(.SLOT_LEN(25), .BORROW(0)) dut_b (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
        .vid_req(vid_req_b), .vid_addr(vid_addr_b), .vid_data(vid_data_b), .vid_ack(vid_ack_b),
        .cpu_phase(cpu_phase_b), .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   acks_a = 0;
    int   acks_b = 0;

    logic [7:0] mem_a [0:32767];
    logic [7:0] mem_b [0:32767];
    logic       loaded = 1'b0;

    // Synchronous RAMs: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (!loaded) begin
            mem_a[15'h3000] <= 8'hA5;
            mem_b[15'h0200] <= 8'h3C;
            ram_rdata_a     <= 8'h00;
            ram_rdata_b     <= 8'h00;
            loaded          <= 1'b1;
        end else begin
            if (ram_en_a) begin
                if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
                ram_rdata_a <= mem_a[ram_addr_a];
            end
            if (ram_en_b) begin
                if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
                ram_rdata_b <= mem_b[ram_addr_b];
            end
        end
    end

    // Cycle index since reset release; cycle 0 is the first slot_cnt==0 cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("phase_a", 32'(cpu_phase_a), 32'(cyc % 50 == 25));
            if (ram_en_a) begin
                if (qa.size() == 0) chk("ram_en_a_unexpected", 32'(ram_en_a), 32'd0);
                else begin
                    chk("ram_en_a_cycle", cyc, qa[0].cyc - 2);
                    chk("ram_we_a", 32'(ram_we_a), 32'(qa[0].we));
                    chk("ram_addr_a", 32'(ram_addr_a), 32'(qa[0].addr));
                    if (qa[0].we) chk("ram_wdata_a", 32'(ram_wdata_a), 32'(qa[0].wdata));
                end
            end else if (ram_we_a) chk("ram_we_a_idle", 32'(ram_we_a), 32'd0);
            if (cpu_ack_a || vid_ack_a) begin
                if (qa.size() == 0) chk("ack_a_unexpected", 32'({cpu_ack_a, vid_ack_a}), 32'd0);
                else begin
                    ea = qa.pop_front();
                    chk("ack_a_kind", 32'({cpu_ack_a, vid_ack_a}), ea.is_cpu ? 32'd2 : 32'd1);
                    chk("ack_a_cycle", cyc, ea.cyc);
                    chk("ack_a_data", 32'(ea.is_cpu ? cpu_rdata_a : vid_data_a), 32'(ea.data));
                    acks_a++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("phase_b", 32'(cpu_phase_b), 32'(cyc % 50 == 25));
            if (ram_en_b) begin
                if (qb.size() == 0) chk("ram_en_b_unexpected", 32'(ram_en_b), 32'd0);
                else begin
                    chk("ram_en_b_cycle", cyc, qb[0].cyc - 2);
                    chk("ram_addr_b", 32'(ram_addr_b), 32'(qb[0].addr));
                end
            end
            if (cpu_ack_b || vid_ack_b) begin
                if (qb.size() == 0) chk("ack_b_unexpected", 32'({cpu_ack_b, vid_ack_b}), 32'd0);
                else begin
                    eb = qb.pop_front();
                    chk("ack_b_kind", 32'({cpu_ack_b, vid_ack_b}), eb.is_cpu ? 32'd2 : 32'd1);
                    chk("ack_b_cycle", cyc, eb.cyc);
                    chk("ack_b_data", 32'(cpu_rdata_b), 32'(eb.data));
                    acks_b++;
                end
            end
        end
    end

    // First slot at or after cycle c; par selects owner parity (1 = CPU), -1 = any.
    function automatic int next_slot(input int c, input int par);
        int s;
        s = (c + 24) / 25;
        if (par >= 0 && (s % 2) != par) s++;
        return s;
    endfunction

    task automatic push_a(input bit c, input bit w, input logic [14:0] ad, input logic [7:0] wd,
                          input logic [7:0] d, input int slot);
        qa.push_back('{is_cpu: c, we: w, addr: ad, wdata: wd, data: d, cyc: 25 * slot + 3});
    endtask

    task automatic goto(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_acks(input bit on_b, input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if ((on_b ? acks_b : acks_a) >= target) break;
            @(posedge clk); #1;
        end
        if ((on_b ? acks_b : acks_a) < target) chk(tag, on_b ? acks_b : acks_a, target);
    endtask

    initial begin
        int s, tgt;
        rst_n = 1'b0;
        cpu_req_a = 0; cpu_we_a = 0; cpu_addr_a = '0; cpu_wdata_a = '0; vid_req_a = 0; vid_addr_a = '0;
        cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0; vid_req_b = 0; vid_addr_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack_a), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack_a), 32'd0);
        chk("rst_cpu_phase", 32'(cpu_phase_a), 32'd0);
        chk("rst_ram_en", 32'(ram_en_a), 32'd0);
        chk("rst_ram_we", 32'(ram_we_a), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr_a), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata_a), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata_a), 32'd0);
        chk("rst_vid_data", 32'(vid_data_a), 32'd0);
        chk("rst_b_ram_en", 32'(ram_en_b), 32'd0);
        rst_n = 1'b1;

        // Idle slots first, then a video fetch arriving mid CPU slot.
        goto(40);
        vid_addr_a = 15'h3000;
        push_a(0, 0, 15'h3000, 8'h00, 8'hA5, next_slot(cyc, -1));
        tgt = acks_a + 1; vid_req_a = 1;
        wait_acks(0, tgt, "timeout_vid_read");
        vid_req_a = 0;

        // CPU write leaves cpu_rdata untouched; the read back borrows a video slot.
        cpu_we_a = 1; cpu_addr_a = 15'h0100; cpu_wdata_a = 8'h5A;
        push_a(1, 1, 15'h0100, 8'h5A, 8'h00, next_slot(cyc, -1));
        tgt = acks_a + 1; cpu_req_a = 1;
        wait_acks(0, tgt, "timeout_cpu_write");
        cpu_req_a = 0; cpu_we_a = 0;
        push_a(1, 0, 15'h0100, 8'h00, 8'h5A, next_slot(cyc, -1));
        tgt = acks_a + 1; cpu_req_a = 1;
        wait_acks(0, tgt, "timeout_cpu_read");
        cpu_req_a = 0;

        // Both held: owner always wins, so acks alternate slot by slot.
        s = next_slot(cyc, -1);
        for (int i = 0; i < 4; i++) begin
            if ((s + i) % 2 == 1) push_a(1, 0, 15'h0100, 8'h00, 8'h5A, s + i);
            else                  push_a(0, 0, 15'h3000, 8'h00, 8'hA5, s + i);
        end
        tgt = acks_a + 4; cpu_req_a = 1; vid_req_a = 1;
        wait_acks(0, tgt, "timeout_alternate");
        cpu_req_a = 0; vid_req_a = 0;

        // CPU alone with borrowing: served in every slot.
        cpu_addr_a = 15'h3000;
        s = next_slot(cyc, -1);
        for (int i = 0; i < 3; i++) push_a(1, 0, 15'h3000, 8'h00, 8'hA5, s + i);
        tgt = acks_a + 3; cpu_req_a = 1;
        wait_acks(0, tgt, "timeout_borrow");
        cpu_req_a = 0;

        // CPU alone without borrowing: only CPU-owned slots.
        cpu_addr_b = 15'h0200;
        s = next_slot(cyc, 1);
        for (int i = 0; i < 2; i++)
            qb.push_back('{is_cpu: 1, we: 0, addr: 15'h0200, wdata: 8'h00, data: 8'h3C, cyc: 25 * (s + 2 * i) + 3});
        tgt = acks_b + 2; cpu_req_b = 1;
        wait_acks(1, tgt, "timeout_no_borrow");
        cpu_req_b = 0;

        // Reset during slot_cnt 2 of a CPU read: the access is dropped.
        s = next_slot(cyc, -1);
        push_a(1, 0, 15'h3000, 8'h00, 8'hA5, s);
        cpu_req_a = 1;
        goto(25 * s + 2);
        rst_n = 1'b0;
        qa.delete();
        cpu_req_a = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_cpu_ack", 32'(cpu_ack_a), 32'd0);
        chk("abort_ram_en", 32'(ram_en_a), 32'd0);
        chk("abort_cpu_rdata", 32'(cpu_rdata_a), 32'd0);
        chk("abort_vid_data", 32'(vid_data_a), 32'd0);
        chk("abort_b_cpu_rdata", 32'(cpu_rdata_b), 32'd0);
        vid_addr_a = 15'h3000;
        push_a(0, 0, 15'h3000, 8'h00, 8'hA5, 0);
        tgt = acks_a + 1; vid_req_a = 1;
        rst_n = 1'b1;
        wait_acks(0, tgt, "timeout_after_reset");
        vid_req_a = 0;
        goto(60);
        chk("post_reset_cpu_rdata", 32'(cpu_rdata_a), 32'd0);
        chk("post_reset_queue_empty", qa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
